// File: rtl/filter_response_meter_if.sv
//==============================================================================
// Module      : filter_response_meter_if
// Description : Sample stream, control handshake and result bus of the
//               filter response meter. The producer/consumer side uses the
//               master modport, the meter uses the slave modport.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface filter_response_meter_if #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 6
);
  logic                       sample_valid;
  logic signed [DATA_W-1:0]   sample_in;
  logic                       start;
  logic                       busy;
  logic                       result_valid;
  logic                       result_ready;
  logic signed [DATA_W-1:0]   peak_pos;
  logic signed [DATA_W-1:0]   peak_neg;
  logic        [DATA_W-1:0]   peak_abs;
  logic        [WIN_LOG2:0]   zero_cross;
  logic        [WIN_LOG2:0]   clip_count;
  logic signed [DATA_W-1:0]   dc_mean;

  modport master (
    output sample_valid, sample_in, start, result_ready,
    input  busy, result_valid, peak_pos, peak_neg, peak_abs,
           zero_cross, clip_count, dc_mean
  );

  modport slave (
    input  sample_valid, sample_in, start, result_ready,
    output busy, result_valid, peak_pos, peak_neg, peak_abs,
           zero_cross, clip_count, dc_mean
  );
endinterface

`default_nettype wire

// File: rtl/filter_response_meter.sv
//==============================================================================
// Module      : filter_response_meter
// Description : Captures a window of 2**WIN_LOG2 signed filter output samples
//               and reports positive/negative peak, saturated |peak|,
//               zero-crossing count and clip count. Optional DC mean is
//               built only when the macro METER_DC_EN is defined; otherwise
//               dc_mean is tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module filter_response_meter #(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 6
) (
  input  wire logic              clk_144,
  input  wire logic              reset,
  filter_response_meter_if.slave bus
);

  localparam logic signed [DATA_W-1:0] C_SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] C_SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [WIN_LOG2-1:0]      C_LAST = '1;
  localparam logic [WIN_LOG2:0]        C_ONE  = (WIN_LOG2+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                    state_q;
  logic [WIN_LOG2-1:0]       cnt_q;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic signed [DATA_W-1:0]  min_q, min_d;
  logic [WIN_LOG2:0]         zc_q, zc_d;
  logic [WIN_LOG2:0]         clip_q, clip_d;
  logic                      prev_neg_q;

  // Registered outputs
  logic                      busy_q;
  logic                      result_valid_q;
  logic signed [DATA_W-1:0]  peak_pos_q;
  logic signed [DATA_W-1:0]  peak_neg_q;
  logic [DATA_W-1:0]         peak_abs_q;
  logic [WIN_LOG2:0]         zero_cross_q;
  logic [WIN_LOG2:0]         clip_count_q;

  logic signed [DATA_W-1:0]  w_sample;
  logic                      w_neg;
  logic signed [DATA_W:0]    w_max_ext, w_min_ext;
  logic [DATA_W:0]           w_abs_max, w_abs_min, w_abs;
  logic [DATA_W-1:0]         w_abs_sat;

`ifdef METER_DC_EN
  logic signed [DATA_W+WIN_LOG2-1:0] acc_q, acc_d;
  logic signed [DATA_W+WIN_LOG2-1:0] w_mean_full;
  logic signed [DATA_W-1:0]          dc_mean_q;
`endif

  // Statistics including the sample currently on the bus; these are the
  // values committed on a strobe, and on the final strobe they are the result.
  always_comb begin
    w_sample = bus.sample_in;
    w_neg    = w_sample[DATA_W-1];
    max_d    = (w_sample > max_q) ? w_sample : max_q;
    min_d    = (w_sample < min_q) ? w_sample : min_q;
    // The first sample of a window only seeds the previous sign.
    zc_d     = ((cnt_q != '0) && (w_neg != prev_neg_q)) ? zc_q + C_ONE : zc_q;
    clip_d   = ((w_sample == C_SMAX) || (w_sample == C_SMIN)) ? clip_q + C_ONE : clip_q;
    // Magnitudes need one extra bit so |most-negative| is representable,
    // then the larger one is clamped back into DATA_W bits.
    w_max_ext = {max_d[DATA_W-1], max_d};
    w_min_ext = {min_d[DATA_W-1], min_d};
    w_abs_max = w_max_ext[DATA_W] ? $unsigned(-w_max_ext) : $unsigned(w_max_ext);
    w_abs_min = w_min_ext[DATA_W] ? $unsigned(-w_min_ext) : $unsigned(w_min_ext);
    w_abs     = (w_abs_max > w_abs_min) ? w_abs_max : w_abs_min;
    w_abs_sat = (w_abs > {1'b0, C_SMAX}) ? C_SMAX : w_abs[DATA_W-1:0];
`ifdef METER_DC_EN
    acc_d       = acc_q + (DATA_W+WIN_LOG2)'(w_sample);
    w_mean_full = acc_d >>> WIN_LOG2;
`endif
  end

  // Control FSM with working statistics and registered result outputs.
  always_ff @(posedge clk_144 or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      max_q          <= '0;
      min_q          <= '0;
      zc_q           <= '0;
      clip_q         <= '0;
      prev_neg_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      peak_pos_q     <= '0;
      peak_neg_q     <= '0;
      peak_abs_q     <= '0;
      zero_cross_q   <= '0;
      clip_count_q   <= '0;
`ifdef METER_DC_EN
      acc_q          <= '0;
      dc_mean_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          // Seed the peaks at the opposite extremes so any sample replaces them.
          max_q      <= C_SMIN;
          min_q      <= C_SMAX;
          cnt_q      <= '0;
          zc_q       <= '0;
          clip_q     <= '0;
          prev_neg_q <= 1'b0;
`ifdef METER_DC_EN
          acc_q      <= '0;
`endif
          state_q    <= S_MEASURE;
        end
        S_MEASURE: begin
          if (bus.sample_valid) begin
            max_q      <= max_d;
            min_q      <= min_d;
            zc_q       <= zc_d;
            clip_q     <= clip_d;
            prev_neg_q <= w_neg;
            cnt_q      <= cnt_q + 1'b1;
`ifdef METER_DC_EN
            acc_q      <= acc_d;
`endif
            if (cnt_q == C_LAST) begin
              peak_pos_q     <= max_d;
              peak_neg_q     <= min_d;
              peak_abs_q     <= w_abs_sat;
              zero_cross_q   <= zc_d;
              clip_count_q   <= clip_d;
`ifdef METER_DC_EN
              dc_mean_q      <= w_mean_full[DATA_W-1:0];
`endif
              result_valid_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.peak_pos     = peak_pos_q;
  assign bus.peak_neg     = peak_neg_q;
  assign bus.peak_abs     = peak_abs_q;
  assign bus.zero_cross   = zero_cross_q;
  assign bus.clip_count   = clip_count_q;
`ifdef METER_DC_EN
  assign bus.dc_mean      = dc_mean_q;
`else
  assign bus.dc_mean      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_response_meter.sv
//==============================================================================
// Module      : tb_filter_response_meter
// Description : Directed self-checking bench for filter_response_meter.
//               Expected dc_mean follows METER_DC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_filter_response_meter;

  logic clk_144;
  logic reset;
  int   n_cmp;
  int   n_err;

  filter_response_meter_if #(.DATA_W(16), .WIN_LOG2(6)) bus ();

  filter_response_meter #(.DATA_W(16), .WIN_LOG2(6)) dut (
    .clk_144 (clk_144),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_144 = 1'b0;
  always #5 clk_144 = ~clk_144;

  // Expected dc_mean: the mean when the feature is built, else 0.
  function automatic int dc_exp(input int mean);
`ifdef METER_DC_EN
    return mean;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_144);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();  // ARM -> MEASURE
  endtask

  task automatic send_sample(input int v, input int gap);
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'(v);
    tick();
    bus.sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic ack();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_144);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", bus.result_valid); end
    n_cmp++; if ({bus.peak_pos, bus.peak_neg, bus.peak_abs, bus.zero_cross, bus.clip_count, bus.dc_mean} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got pos=%0d neg=%0d abs=%0d zc=%0d clip=%0d dc=%0d want all 0",
        bus.peak_pos, bus.peak_neg, bus.peak_abs, bus.zero_cross, bus.clip_count, bus.dc_mean);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sine();
    real v;
    int  s;
    pulse_start();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sine_busy: got %b want 1", bus.busy); end
    for (int n = 0; n < 64; n++) begin
      v = 32767.0 * $sin(2.0 * 3.14159265358979 * n / 48.0);
      s = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      if (n == 63) begin
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL sine_early_rv: got %b want 0", bus.result_valid); end
      end
      send_sample(s, 0);
    end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL sine_rv_latency: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL sine_busy_hold: got %b want 0", bus.busy); end
    n_cmp++; if (bus.peak_pos !== 16'sd32767) begin n_err++; $display("FAIL sine_pos: got %0d want 32767", bus.peak_pos); end
    n_cmp++; if (bus.peak_neg !== -16'sd32767) begin n_err++; $display("FAIL sine_neg: got %0d want -32767", bus.peak_neg); end
    n_cmp++; if (bus.peak_abs !== 16'd32767) begin n_err++; $display("FAIL sine_abs: got %0d want 32767", bus.peak_abs); end
    n_cmp++; if (bus.zero_cross !== 7'd2) begin n_err++; $display("FAIL sine_zc: got %0d want 2", bus.zero_cross); end
    n_cmp++; if (bus.clip_count !== 7'd2) begin n_err++; $display("FAIL sine_clip: got %0d want 2", bus.clip_count); end
    ack();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL sine_ack: got %b want 0", bus.result_valid); end
  endtask

  task automatic test_const_neg();
    pulse_start();
    for (int n = 0; n < 64; n++) send_sample(-32768, 0);
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL cneg_rv: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.peak_pos !== -16'sd32768) begin n_err++; $display("FAIL cneg_pos: got %0d want -32768", bus.peak_pos); end
    n_cmp++; if (bus.peak_neg !== -16'sd32768) begin n_err++; $display("FAIL cneg_neg: got %0d want -32768", bus.peak_neg); end
    n_cmp++; if (bus.peak_abs !== 16'd32767) begin n_err++; $display("FAIL cneg_abs_sat: got %0d want 32767", bus.peak_abs); end
    n_cmp++; if (bus.zero_cross !== 7'd0) begin n_err++; $display("FAIL cneg_zc: got %0d want 0", bus.zero_cross); end
    n_cmp++; if (bus.clip_count !== 7'd64) begin n_err++; $display("FAIL cneg_clip: got %0d want 64", bus.clip_count); end
    n_cmp++; if (int'(bus.dc_mean) !== dc_exp(-32768)) begin n_err++; $display("FAIL cneg_dc: got %0d want %0d", bus.dc_mean, dc_exp(-32768)); end
    ack();
  endtask

  task automatic test_alternating();
    pulse_start();
    for (int n = 0; n < 64; n++) send_sample((n % 2 == 0) ? 7094 : -7094, 0);
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL alt_rv: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.zero_cross !== 7'd63) begin n_err++; $display("FAIL alt_zc: got %0d want 63", bus.zero_cross); end
    n_cmp++; if (bus.peak_abs !== 16'd7094) begin n_err++; $display("FAIL alt_abs: got %0d want 7094", bus.peak_abs); end
    n_cmp++; if (bus.peak_pos !== 16'sd7094) begin n_err++; $display("FAIL alt_pos: got %0d want 7094", bus.peak_pos); end
    n_cmp++; if (bus.peak_neg !== -16'sd7094) begin n_err++; $display("FAIL alt_neg: got %0d want -7094", bus.peak_neg); end
    n_cmp++; if (bus.clip_count !== 7'd0) begin n_err++; $display("FAIL alt_clip: got %0d want 0", bus.clip_count); end
    n_cmp++; if (int'(bus.dc_mean) !== dc_exp(0)) begin n_err++; $display("FAIL alt_dc: got %0d want %0d", bus.dc_mean, dc_exp(0)); end
    ack();
  endtask

  task automatic test_hold_stall();
    pulse_start();
    for (int n = 0; n < 64; n++) send_sample(1234, 0);
    // ready low for 20 cycles while start and clipping samples are offered
    for (int c = 0; c < 20; c++) begin
      bus.start        = (c == 5);
      bus.sample_valid = (c >= 8 && c < 16);
      bus.sample_in    = 16'sh7fff;
      tick();
      n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL hold_rv c=%0d: got %b want 1", c, bus.result_valid); end
    end
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL hold_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.peak_pos !== 16'sd1234) begin n_err++; $display("FAIL hold_pos: got %0d want 1234", bus.peak_pos); end
    n_cmp++; if (bus.peak_abs !== 16'd1234) begin n_err++; $display("FAIL hold_abs: got %0d want 1234", bus.peak_abs); end
    n_cmp++; if (bus.clip_count !== 7'd0) begin n_err++; $display("FAIL hold_clip: got %0d want 0", bus.clip_count); end
    n_cmp++; if (int'(bus.dc_mean) !== dc_exp(1234)) begin n_err++; $display("FAIL hold_dc: got %0d want %0d", bus.dc_mean, dc_exp(1234)); end
    ack();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL hold_ack_rv: got %b want 0", bus.result_valid); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL hold_no_restart: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_midwindow();
    int s;
    pulse_start();
    for (int n = 0; n < 30; n++) send_sample(20000, 0);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.peak_pos, bus.peak_abs, bus.result_valid} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got pos=%0d abs=%0d rv=%b want 0", bus.peak_pos, bus.peak_abs, bus.result_valid);
    end
    #2;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++; $display("FAIL rstmid_quiet c=%0d: got rv=%b busy=%b want 0 0", c, bus.result_valid, bus.busy);
      end
    end
    pulse_start();
    for (int n = 0; n < 64; n++) begin
      s = n - 32;
      send_sample(s, 0);
    end
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL ramp_rv: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.peak_pos !== 16'sd31) begin n_err++; $display("FAIL ramp_pos: got %0d want 31", bus.peak_pos); end
    n_cmp++; if (bus.peak_neg !== -16'sd32) begin n_err++; $display("FAIL ramp_neg: got %0d want -32", bus.peak_neg); end
    n_cmp++; if (bus.peak_abs !== 16'd32) begin n_err++; $display("FAIL ramp_abs: got %0d want 32", bus.peak_abs); end
    n_cmp++; if (bus.zero_cross !== 7'd1) begin n_err++; $display("FAIL ramp_zc: got %0d want 1", bus.zero_cross); end
    n_cmp++; if (int'(bus.dc_mean) !== dc_exp(-1)) begin n_err++; $display("FAIL ramp_dc: got %0d want %0d", bus.dc_mean, dc_exp(-1)); end
    ack();
  endtask

  task automatic test_spaced_strobes();
    pulse_start();
    for (int n = 0; n < 63; n++) begin
      send_sample(100, 2);
      if (n == 20) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL spaced_busy: got %b want 1", bus.busy); end
      end
    end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL spaced_early_rv: got %b want 0", bus.result_valid); end
    send_sample(-200, 0);
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL spaced_rv_latency: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.peak_pos !== 16'sd100) begin n_err++; $display("FAIL spaced_pos: got %0d want 100", bus.peak_pos); end
    n_cmp++; if (bus.peak_neg !== -16'sd200) begin n_err++; $display("FAIL spaced_neg: got %0d want -200", bus.peak_neg); end
    n_cmp++; if (bus.peak_abs !== 16'd200) begin n_err++; $display("FAIL spaced_abs: got %0d want 200", bus.peak_abs); end
    n_cmp++; if (bus.zero_cross !== 7'd1) begin n_err++; $display("FAIL spaced_zc: got %0d want 1", bus.zero_cross); end
    n_cmp++; if (int'(bus.dc_mean) !== dc_exp(95)) begin n_err++; $display("FAIL spaced_dc: got %0d want %0d", bus.dc_mean, dc_exp(95)); end
    // start together with ready in HOLD: handshake completes, start dropped
    bus.start        = 1'b1;
    bus.result_ready = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL spaced_ack_rv: got %b want 0", bus.result_valid); end
    tick();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL spaced_start_dropped: got %b want 0", bus.busy); end
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    test_reset();
    test_sine();
    test_const_neg();
    test_alternating();
    test_hold_stall();
    test_reset_midwindow();
    test_spaced_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
